aoc7_stream_ctrl: RTL and testbench
===================================

// Module: aoc7_stream_ctrl
// PURPOSE
//  Upstream feeder and result collector for the day-7 beam splitter. Takes the raw ASCII puzzle
//  stream (valid/ready), maps each grid cell to one splitter step (split_en/split_in), checks row
//  geometry, then runs a drain pass over the splitter's rotating row and sums count_out into the
//  final timeline total. It also counts splits that actually fire (part 1).
// PARAMETERS
//  LINE_LENGTH  141  grid columns per row; must equal the splitter's LINE_LENGTH
//  RESULT_WIDTH 64   width of result_timelines accumulator (>= `DATA_WIDTH)
//  SPLIT_WIDTH  32   width of result_splits counter
// PORTS
//  clock             in   1             rising-edge clock
//  reset_n           in   1             async active-low reset
//  start             in   1             1-cycle pulse in S_DONE: clear results/errors, back to S_FEED
//  in_valid          in   1             input byte valid
//  in_data           in   8             ASCII byte
//  in_last           in   1             qualifies final byte of the file
//  in_ready          out  1             byte accepted when in_valid && in_ready
//  split_en          out  1             splitter en (one rotation step)
//  split_in          out  1             splitter split_in ('^' at current column)
//  count_out         in   `DATA_WIDTH   splitter count_out (timelines at current column)
//  busy              out  1             high in S_FEED/S_EOL/S_PAD/S_DRAIN
//  result_valid      out  1             high in S_DONE only
//  result_timelines  out  RESULT_WIDTH  sum of all columns after last row
//  result_splits     out  SPLIT_WIDTH   count of '^' cells hit with count_out != 0
//  err_line_len      out  1             sticky: a row was short or long
//  err_char          out  1             sticky: byte outside {'.','^','S','\r','\n'}
// BEHAVIOUR
//  Reset (async, reset_n=0): state S_FEED, col=0, acc=0, splits=0, both errs=0, result_valid=0,
//   pad_to_drain=0. Splitter reset is owned by the top level and must coincide with reset_n/start.
//  in_ready = state in {S_FEED,S_EOL}; decoded from state only, no comb path from in_valid.
//  split_en/split_in combinational; one split_en per column, so the splitter stays row-aligned.
//  S_FEED, accepted byte:
//   '.','S' -> split_en=1,split_in=0; '^' -> split_en=1,split_in=1; other char -> err_char,
//   treated as '.'; col++. At col==L-1 -> S_EOL, col=0.
//   '\r' ignored. '\n' with col==0 ignored (blank line). '\n' with col>0 -> err_line_len, S_PAD.
//   in_last on a cell byte: if it completes the row -> S_DRAIN, else pad_to_drain=1, S_PAD.
//   in_last on '\n'/'\r': col==0 -> S_DRAIN; col>0 -> err_line_len, pad_to_drain=1, S_PAD.
//  S_EOL: '\r' ignored; '\n' -> S_FEED; cell/other byte -> err_line_len, byte dropped
//   (no split_en), stay. in_last in S_EOL -> S_DRAIN.
//  S_PAD: split_en=1,split_in=0 per cycle, col++ until col==L-1 then col=0 and -> S_DRAIN if
//   pad_to_drain else S_FEED.
//  S_DRAIN: L cycles, split_en=1,split_in=0, acc += zero-extend(count_out) each cycle; -> S_DONE.
//  splits += 1 whenever split_en && split_in && count_out != 0 (same cycle).
//  S_DONE: in_ready=0, split_en=0, outputs held; start -> clear acc/splits/errs, col=0, S_FEED.
//   start outside S_DONE ignored. acc/splits wrap modulo 2^width (no saturation).
//  Drain adds L cycles latency after the last row; result_valid rises the cycle after the last
//  drain step. Reset mid-operation aborts instantly to the reset state; no partial result kept.
// STRUCTURE
//  Shared package aoc7_pkg: state enum (S_FEED,S_EOL,S_PAD,S_DRAIN,S_DONE), ASCII constants
//   CH_DOT/CH_SPLIT/CH_START/CH_CR/CH_LF, function is_cell(byte).
//  Sub-module aoc7_char_decode: byte -> {is_cell, is_split, is_eol, is_cr, is_bad}; comb only.
//  Column counter width $clog2(LINE_LENGTH); one FSM; accumulator + split counter in this file.
// TESTING (L=5, with splitter instance attached)
//  "..S..\n..^..\n.....\n" last on final '\n' -> timelines=2, splits=1, no errs, 15+5 en pulses
//  "..S..\r\n..^..\r\n" -> CRs ignored, timelines=2, splits=1, same as LF-only
//  "..S..\n.^...\n" -> '^' under zero beam: splits=0, timelines=1
//  "..S..\n..^\n.....\n" -> err_line_len=1, 2 pad cycles, row 3 still aligned, timelines=2
//  "..S..\n..x..\n" -> err_char=1, x as '.', timelines=1; then start -> results/errs cleared
//  in_valid held with random gaps + reset_n pulse mid-row -> all outputs at reset values, no en

Source files
------------

// File: rtl/aoc7_pkg.sv
// rtl/aoc7_pkg.sv - shared types and ASCII constants for the day-7 stream controller
package aoc7_pkg;

    localparam int DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        S_FEED,
        S_EOL,
        S_PAD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_SPLIT = 8'h5E;
    localparam logic [7:0] CH_START = 8'h53;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // A grid cell is any byte that occupies one splitter column.
    function automatic logic is_cell(input logic [7:0] b);
        return (b == CH_DOT) || (b == CH_SPLIT) || (b == CH_START);
    endfunction

endpackage

// File: rtl/aoc7_stream_ctrl_if.sv
// rtl/aoc7_stream_ctrl_if.sv - byte stream handshake into the stream controller
interface aoc7_stream_ctrl_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/aoc7_char_decode.sv
// rtl/aoc7_char_decode.sv - classify one ASCII byte of the puzzle input
module aoc7_char_decode
    import aoc7_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_cell_o,
    output logic       is_split_o,
    output logic       is_eol_o,
    output logic       is_cr_o,
    output logic       is_bad_o
);

    // Pure byte classification; anything unrecognised is flagged bad.
    always_comb begin
        is_cell_o  = is_cell(byte_i);
        is_split_o = (byte_i == CH_SPLIT);
        is_eol_o   = (byte_i == CH_LF);
        is_cr_o    = (byte_i == CH_CR);
        is_bad_o   = !(is_cell_o || is_eol_o || is_cr_o);
    end

endmodule

// File: rtl/aoc7_stream_ctrl.sv
// rtl/aoc7_stream_ctrl.sv - feeds the beam splitter from the ASCII stream and collects results
module aoc7_stream_ctrl
    import aoc7_pkg::*;
#(
    parameter int LINE_LENGTH  = 141,
    parameter int RESULT_WIDTH = 64,
    parameter int SPLIT_WIDTH  = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    aoc7_stream_ctrl_if.slave       in_if,
    output logic                    split_en,
    output logic                    split_in,
    input  logic [DATA_WIDTH-1:0]   count_out,
    output logic                    busy,
    output logic                    result_valid,
    output logic [RESULT_WIDTH-1:0] result_timelines,
    output logic [SPLIT_WIDTH-1:0]  result_splits,
    output logic                    err_line_len,
    output logic                    err_char
);

    localparam int CW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_LENGTH - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic                    pad_q, pad_d;
    logic [RESULT_WIDTH-1:0] acc_q, acc_d;
    logic [SPLIT_WIDTH-1:0]  splits_q, splits_d;
    logic                    err_len_q, err_len_d;
    logic                    err_char_q, err_char_d;
    logic                    drain_add;
    logic                    clr;

    logic in_ready_w;
    logic accept;
    logic d_cell, d_split, d_eol, d_cr, d_bad;

    aoc7_char_decode u_decode (
        .byte_i     (in_if.in_data),
        .is_cell_o  (d_cell),
        .is_split_o (d_split),
        .is_eol_o   (d_eol),
        .is_cr_o    (d_cr),
        .is_bad_o   (d_bad)
    );

    assign in_ready_w       = (state_q == S_FEED) || (state_q == S_EOL);
    assign in_if.in_ready   = in_ready_w;
    assign accept           = in_if.in_valid && in_ready_w;
    assign busy             = (state_q != S_DONE);
    assign result_valid     = (state_q == S_DONE);
    assign result_timelines = acc_q;
    assign result_splits    = splits_q;
    assign err_line_len     = err_len_q;
    assign err_char         = err_char_q;

    // State, column and sticky-flag registers; reset aborts any row in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FEED;
            col_q      <= '0;
            pad_q      <= 1'b0;
            acc_q      <= '0;
            splits_q   <= '0;
            err_len_q  <= 1'b0;
            err_char_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            pad_q      <= pad_d;
            acc_q      <= acc_d;
            splits_q   <= splits_d;
            err_len_q  <= err_len_d;
            err_char_q <= err_char_d;
        end
    end

    // Next-state and splitter step generation: exactly one split_en per column.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        pad_d      = pad_q;
        err_len_d  = err_len_q;
        err_char_d = err_char_q;
        split_en   = 1'b0;
        split_in   = 1'b0;
        drain_add  = 1'b0;
        clr        = 1'b0;

        case (state_q)
            S_FEED: begin
                if (accept) begin
                    if (d_cell || d_bad) begin
                        // Bad bytes still consume a column so later rows stay aligned.
                        split_en = 1'b1;
                        split_in = d_split;
                        if (d_bad) err_char_d = 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            state_d = in_if.in_last ? S_DRAIN : S_EOL;
                        end else begin
                            col_d = col_q + CW'(1);
                            if (in_if.in_last) begin
                                pad_d   = 1'b1;
                                state_d = S_PAD;
                            end
                        end
                    end else if (d_eol || (d_cr && in_if.in_last)) begin
                        if (col_q == '0) begin
                            if (in_if.in_last) state_d = S_DRAIN;
                        end else begin
                            err_len_d = 1'b1;
                            pad_d     = in_if.in_last;
                            state_d   = S_PAD;
                        end
                    end
                end
            end
            S_EOL: begin
                if (accept) begin
                    if (d_cell || d_bad) begin
                        err_len_d = 1'b1;
                        if (d_bad) err_char_d = 1'b1;
                    end
                    if (in_if.in_last)  state_d = S_DRAIN;
                    else if (d_eol)     state_d = S_FEED;
                end
            end
            S_PAD: begin
                split_en = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    pad_d   = 1'b0;
                    state_d = pad_q ? S_DRAIN : S_FEED;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DRAIN: begin
                split_en  = 1'b1;
                drain_add = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    clr        = 1'b1;
                    col_d      = '0;
                    pad_d      = 1'b0;
                    err_len_d  = 1'b0;
                    err_char_d = 1'b0;
                    state_d    = S_FEED;
                end
            end
            default: state_d = S_FEED;
        endcase
    end

    // Timeline accumulator and fired-split counter, both wrapping.
    always_comb begin
        acc_d    = acc_q;
        splits_d = splits_q;
        if (clr) begin
            acc_d    = '0;
            splits_d = '0;
        end else begin
            if (drain_add) acc_d = acc_q + RESULT_WIDTH'(count_out);
            if (split_en && split_in && (count_out != '0)) splits_d = splits_q + SPLIT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_aoc7_stream_ctrl.sv
// tb/tb_aoc7_stream_ctrl.sv - self-checking bench with behavioural splitter and result scoreboard
module tb_aoc7_stream_ctrl;
    import aoc7_pkg::*;

    localparam int L = 5;

    typedef struct {
        logic [63:0] tl;
        logic [31:0] sp;
        logic        el;
        logic        ec;
        int          en;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        split_en, split_in;
    logic [DATA_WIDTH-1:0] count_out;
    logic        busy, result_valid;
    logic [63:0] result_timelines;
    logic [31:0] result_splits;
    logic        err_line_len, err_char;

    int   checks = 0;
    int   failures = 0;
    int   en_cnt = 0;
    int   en_base = 0;
    exp_t sb[$];

    aoc7_stream_ctrl_if bus ();

    aoc7_stream_ctrl #(.LINE_LENGTH(L), .RESULT_WIDTH(64), .SPLIT_WIDTH(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .in_if            (bus.slave),
        .split_en         (split_en),
        .split_in         (split_in),
        .count_out        (count_out),
        .busy             (busy),
        .result_valid     (result_valid),
        .result_timelines (result_timelines),
        .result_splits    (result_splits),
        .err_line_len     (err_line_len),
        .err_char         (err_char)
    );

    always #5 clock = ~clock;

    // Behavioural splitter: cur holds this row's beams, nxt collects the next row.
    logic [DATA_WIDTH-1:0] cur[L], nxt[L], cur_n[L], nxt_n[L];
    int p, p_n;

    assign count_out = cur[p];

    always_comb begin
        for (int i = 0; i < L; i++) begin
            cur_n[i] = cur[i];
            nxt_n[i] = nxt[i];
        end
        p_n = p;
        if (split_en) begin
            if (split_in) begin
                if (p > 0)     nxt_n[p-1] = nxt_n[p-1] + cur[p];
                if (p < L - 1) nxt_n[p+1] = nxt_n[p+1] + cur[p];
            end else begin
                nxt_n[p] = nxt_n[p] + cur[p];
            end
            if (p == L - 1) begin
                for (int i = 0; i < L; i++) begin
                    cur_n[i] = nxt_n[i];
                    nxt_n[i] = '0;
                end
                p_n = 0;
            end else begin
                p_n = p + 1;
            end
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n || (start && result_valid)) begin
            for (int i = 0; i < L; i++) begin
                cur[i] <= (i == L / 2) ? 64'd1 : 64'd0;
                nxt[i] <= '0;
            end
            p <= 0;
        end else begin
            for (int i = 0; i < L; i++) begin
                cur[i] <= cur_n[i];
                nxt[i] <= nxt_n[i];
            end
            p <= p_n;
        end
    end

    always @(posedge clock) begin
        if (reset_n && split_en) en_cnt <= en_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
        int n = 0;
        if (gaps) begin
            int g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) @(negedge clock);
        end
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], (i == s.len() - 1), gaps);
    endtask

    task automatic push_exp(input logic [63:0] tl, input logic [31:0] sp,
                            input logic el, input logic ec, input int en);
        exp_t e;
        e.tl = tl; e.sp = sp; e.el = el; e.ec = ec; e.en = en;
        sb.push_back(e);
    endtask

    task automatic collect(input string name);
        exp_t e;
        int lat = 0;
        while (!result_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checks++;
        if (result_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s result_valid_timeout got=%0b required=1", name, result_valid);
            return;
        end
        checks++;
        if (lat !== L) begin
            failures++;
            $display("FAIL %s drain_latency got=%0d required=%0d", name, lat, L);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard_empty got=0 required=1", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (result_timelines !== e.tl) begin
            failures++;
            $display("FAIL %s timelines got=%0d required=%0d", name, result_timelines, e.tl);
        end
        checks++;
        if (result_splits !== e.sp) begin
            failures++;
            $display("FAIL %s splits got=%0d required=%0d", name, result_splits, e.sp);
        end
        checks++;
        if ({err_line_len, err_char} !== {e.el, e.ec}) begin
            failures++;
            $display("FAIL %s errs got=%b%b required=%b%b", name, err_line_len, err_char, e.el, e.ec);
        end
        checks++;
        if ((en_cnt - en_base) !== e.en) begin
            failures++;
            $display("FAIL %s en_pulses got=%0d required=%0d", name, en_cnt - en_base, e.en);
        end
        checks++;
        if ({busy, bus.in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL %s done_flags busy/ready got=%b%b required=00", name, busy, bus.in_ready);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (result_timelines !== e.tl || result_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s hold got=%0d/%0b required=%0d/1", name, result_timelines, result_valid, e.tl);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({result_valid, busy, err_line_len, err_char} !== 4'b0100 ||
            result_timelines !== 64'd0 || result_splits !== 32'd0) begin
            failures++;
            $display("FAIL %s start_clear rv/busy/el/ec=%b%b%b%b tl=%0d sp=%0d required=0100 0 0",
                     name, result_valid, busy, err_line_len, err_char, result_timelines, result_splits);
        end
        en_base = en_cnt;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, result_valid, bus.in_ready, split_en, err_line_len, err_char} !== 6'b101000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=101000",
                     {busy, result_valid, bus.in_ready, split_en, err_line_len, err_char});
        end
        checks++;
        if (result_timelines !== 64'd0 || result_splits !== 32'd0) begin
            failures++;
            $display("FAIL reset_results got=%0d/%0d required=0/0", result_timelines, result_splits);
        end
    endtask

    task automatic test_basic();
        push_exp(64'd2, 32'd1, 1'b0, 1'b0, 20);
        send_str("..S..\n..^..\n.....\n", 1'b0);
        collect("basic");
    endtask

    task automatic test_crlf();
        push_exp(64'd2, 32'd1, 1'b0, 1'b0, 15);
        send_str("..S..\r\n..^..\r\n", 1'b0);
        collect("crlf");
    endtask

    task automatic test_zero_beam();
        push_exp(64'd1, 32'd0, 1'b0, 1'b0, 15);
        send_str("..S..\n.^...\n", 1'b0);
        collect("zero_beam");
    endtask

    task automatic test_short_row();
        push_exp(64'd2, 32'd1, 1'b1, 1'b0, 20);
        send_str("..S..\n..^\n.....\n", 1'b0);
        collect("short_row");
    endtask

    task automatic test_bad_char();
        push_exp(64'd1, 32'd0, 1'b0, 1'b1, 15);
        send_str("..S..\n..x..\n", 1'b0);
        collect("bad_char");
    endtask

    task automatic test_gaps_reset();
        int snap;
        send_str("..S..\n..", 1'b1);
        @(negedge clock);
        snap = en_cnt;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, result_valid, bus.in_ready, split_en, err_line_len, err_char} !== 6'b101000 ||
            result_timelines !== 64'd0 || result_splits !== 32'd0) begin
            failures++;
            $display("FAIL midrow_reset flags=%b tl=%0d sp=%0d required=101000 0 0",
                     {busy, result_valid, bus.in_ready, split_en, err_line_len, err_char},
                     result_timelines, result_splits);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (en_cnt !== snap) begin
            failures++;
            $display("FAIL reset_no_en got=%0d required=%0d", en_cnt - snap, 0);
        end
        en_base = en_cnt;
        push_exp(64'd2, 32'd1, 1'b0, 1'b0, 15);
        send_str("..S..\n..^..\n", 1'b1);
        collect("gaps_after_reset");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        en_base = en_cnt;
        test_basic();
        test_crlf();
        test_zero_beam();
        test_short_row();
        test_bad_char();
        test_gaps_reset();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached=1 required=0");
        $fatal(1, "timeout");
    end

endmodule
